// File: rtl/spi_master_seq.sv
//------------------------------------------------------------------------------
// Module   : spi_master_seq
// Purpose  : Transaction sequencer sitting in front of a single-shot SPI
//            master. Outgoing words are buffered in a TX FIFO, launched one
//            at a time with a single-cycle start pulse, tracked through the
//            master's LOAD strobe, and the received word is captured into an
//            RX FIFO. A watchdog abandons frames that never complete.
// Ports    : clk      - system clock, rising edge
//            clr      - asynchronous active-low reset
//            tx_dat   - word to transmit         tx_we   - write strobe
//            tx_full  - TX FIFO full             tx_cnt  - TX occupancy
//            rx_dat   - RX FIFO head             rx_vld  - RX non-empty
//            rx_rd    - RX pop strobe
//            st       - start pulse to master    MTX_DAT - word to master
//            LOAD     - master idle (1) / busy (0)
//            MRX_DAT  - word received by master
//            busy     - sequencer not idle       err     - watchdog timeout
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module spi_master_seq #(
   parameter int m     = 16,
   parameter int DEPTH = 4,
   parameter int GAP   = 2,
   parameter int TMO   = 255
) (
   input  logic                     clk,
   input  logic                     clr,
   input  logic [m-1:0]             tx_dat,
   input  logic                     tx_we,
   output logic                     tx_full,
   output logic [$clog2(DEPTH):0]   tx_cnt,
   output logic [m-1:0]             rx_dat,
   output logic                     rx_vld,
   input  logic                     rx_rd,
   output logic                     st,
   output logic [m-1:0]             MTX_DAT,
   input  logic                     LOAD,
   input  logic [m-1:0]             MRX_DAT,
   output logic                     busy,
   output logic                     err
);

   localparam int AW  = $clog2(DEPTH);
   localparam int CW  = AW + 1;
   localparam int WDW = (TMO < 2) ? 1 : $clog2(TMO + 1);
   localparam int GW  = (GAP < 2) ? 1 : $clog2(GAP + 1);

   localparam logic [CW-1:0]  C_DEPTH    = CW'(DEPTH);
   localparam logic [WDW-1:0] C_TMO      = WDW'(TMO);
   localparam logic [WDW-1:0] C_WD_MAX   = {WDW{1'b1}};
   localparam logic [GW-1:0]  C_GAP_LAST = GW'((GAP > 0) ? (GAP - 1) : 0);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_START   = 3'd1,
      S_WAIT_LO = 3'd2,
      S_WAIT_HI = 3'd3,
      S_CAPTURE = 3'd4,
      S_GAP     = 3'd5
   } state_t;

   // ---------------------------------------------------------------- storage
   logic [m-1:0]  tx_mem_q [DEPTH];
   logic [m-1:0]  rx_mem_q [DEPTH];

   logic [AW-1:0] tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d;
   logic [CW-1:0] tx_cnt_q, tx_cnt_d;
   logic [AW-1:0] rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
   logic [CW-1:0] rx_cnt_q, rx_cnt_d;

   state_t         state_q, state_d;
   logic [m-1:0]   mtx_q, mtx_d;
   logic           st_q, st_d;
   logic           err_q, err_d;
   logic           busy_q, busy_d;
   logic [WDW-1:0] wdog_q, wdog_d;
   logic [GW-1:0]  gap_q, gap_d;

   logic           tx_push, tx_pop, rx_push, rx_pop;
   logic [WDW-1:0] wdog_inc;
   logic           wdog_hit;

   assign tx_push = tx_we && !tx_full;
   assign rx_pop  = rx_rd && rx_vld;

   // Saturating increment; the timeout fires in the cycle the counter
   // would reach TMO, so err appears TMO+1 cycles after START.
   assign wdog_inc = (wdog_q == C_WD_MAX) ? wdog_q : (wdog_q + 1'b1);
   assign wdog_hit = (wdog_inc >= C_TMO);

   // ------------------------------------------------------------ next state
   always_comb begin
      state_d = state_q;
      mtx_d   = mtx_q;
      st_d    = 1'b0;
      err_d   = 1'b0;
      wdog_d  = wdog_q;
      gap_d   = gap_q;
      tx_pop  = 1'b0;
      rx_push = 1'b0;

      case (state_q)
         S_IDLE: begin
            // Only launch when the result is guaranteed a slot in RX.
            if ((tx_cnt_q != '0) && (rx_cnt_q < C_DEPTH)) begin
               state_d = S_START;
               tx_pop  = 1'b1;
               mtx_d   = tx_mem_q[tx_rp_q];
               st_d    = 1'b1;
            end
         end
         S_START: begin
            state_d = S_WAIT_LO;
            wdog_d  = '0;
         end
         S_WAIT_LO: begin
            if (!LOAD) begin
               state_d = S_WAIT_HI;
               wdog_d  = '0;
            end else if (wdog_hit) begin
               err_d   = 1'b1;
               gap_d   = '0;
               state_d = (GAP == 0) ? S_IDLE : S_GAP;
            end else begin
               wdog_d  = wdog_inc;
            end
         end
         S_WAIT_HI: begin
            if (LOAD) begin
               state_d = S_CAPTURE;
            end else if (wdog_hit) begin
               err_d   = 1'b1;
               gap_d   = '0;
               state_d = (GAP == 0) ? S_IDLE : S_GAP;
            end else begin
               wdog_d  = wdog_inc;
            end
         end
         S_CAPTURE: begin
            rx_push = 1'b1;
            gap_d   = '0;
            state_d = (GAP == 0) ? S_IDLE : S_GAP;
         end
         S_GAP: begin
            if (gap_q == C_GAP_LAST) begin
               state_d = S_IDLE;
            end else begin
               gap_d = gap_q + 1'b1;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // busy is registered from the next state so it tracks state_q exactly.
      busy_d = (state_d != S_IDLE);
   end

   // --------------------------------------------------------- FIFO pointers
   always_comb begin
      tx_wp_d  = tx_push ? (tx_wp_q + 1'b1) : tx_wp_q;
      tx_rp_d  = tx_pop  ? (tx_rp_q + 1'b1) : tx_rp_q;
      tx_cnt_d = tx_cnt_q;
      case ({tx_push, tx_pop})
         2'b10:   tx_cnt_d = tx_cnt_q + 1'b1;
         2'b01:   tx_cnt_d = tx_cnt_q - 1'b1;
         default: tx_cnt_d = tx_cnt_q;
      endcase

      rx_wp_d  = rx_push ? (rx_wp_q + 1'b1) : rx_wp_q;
      rx_rp_d  = rx_pop  ? (rx_rp_q + 1'b1) : rx_rp_q;
      rx_cnt_d = rx_cnt_q;
      case ({rx_push, rx_pop})
         2'b10:   rx_cnt_d = rx_cnt_q + 1'b1;
         2'b01:   rx_cnt_d = rx_cnt_q - 1'b1;
         default: rx_cnt_d = rx_cnt_q;
      endcase
   end

   // ------------------------------------------------------------- registers
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         state_q  <= S_IDLE;
         mtx_q    <= '0;
         st_q     <= 1'b0;
         err_q    <= 1'b0;
         busy_q   <= 1'b0;
         wdog_q   <= '0;
         gap_q    <= '0;
         tx_wp_q  <= '0;
         tx_rp_q  <= '0;
         tx_cnt_q <= '0;
         rx_wp_q  <= '0;
         rx_rp_q  <= '0;
         rx_cnt_q <= '0;
      end else begin
         state_q  <= state_d;
         mtx_q    <= mtx_d;
         st_q     <= st_d;
         err_q    <= err_d;
         busy_q   <= busy_d;
         wdog_q   <= wdog_d;
         gap_q    <= gap_d;
         tx_wp_q  <= tx_wp_d;
         tx_rp_q  <= tx_rp_d;
         tx_cnt_q <= tx_cnt_d;
         rx_wp_q  <= rx_wp_d;
         rx_rp_q  <= rx_rp_d;
         rx_cnt_q <= rx_cnt_d;
      end
   end

   // FIFO data arrays need no reset: occupancy counters gate every read.
   always_ff @(posedge clk) begin
      if (tx_push) begin
         tx_mem_q[tx_wp_q] <= tx_dat;
      end
      if (rx_push) begin
         rx_mem_q[rx_wp_q] <= MRX_DAT;
      end
   end

   // --------------------------------------------------------------- outputs
   assign tx_full = (tx_cnt_q == C_DEPTH);
   assign tx_cnt  = tx_cnt_q;
   assign rx_vld  = (rx_cnt_q != '0);
   // Masked so the head reads zero while empty (storage is not reset).
   assign rx_dat  = rx_vld ? rx_mem_q[rx_rp_q] : '0;
   assign st      = st_q;
   assign MTX_DAT = mtx_q;
   assign busy    = busy_q;
   assign err     = err_q;

endmodule

`default_nettype wire
